// File: rtl/data_memory_arbiter_if.sv
// Core, external and data-memory signal bundle for data_memory_arbiter.
// slave = arbiter view, master = requester/memory view.
interface data_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  c_req_i;
    logic                  c_we_i;
    logic [ADDR_WIDTH-1:0] c_addr_i;
    logic [DATA_WIDTH-1:0] c_wdata_i;
    logic                  c_ack_o;
    logic [DATA_WIDTH-1:0] c_rdata_o;
    logic                  c_stall_o;

    logic                  e_req_i;
    logic                  e_we_i;
    logic [ADDR_WIDTH-1:0] e_addr_i;
    logic [DATA_WIDTH-1:0] e_wdata_i;
    logic                  e_ack_o;
    logic [DATA_WIDTH-1:0] e_rdata_o;

    logic                  Mem_Write_o;
    logic                  Mem_Read_o;
    logic [ADDR_WIDTH-1:0] Address_o;
    logic [DATA_WIDTH-1:0] Write_Data_o;
    logic [DATA_WIDTH-1:0] Read_Data_i;
    logic                  busy_o;

    modport slave (
        input  c_req_i, c_we_i, c_addr_i, c_wdata_i,
        output c_ack_o, c_rdata_o, c_stall_o,
        input  e_req_i, e_we_i, e_addr_i, e_wdata_i,
        output e_ack_o, e_rdata_o,
        output Mem_Write_o, Mem_Read_o, Address_o, Write_Data_o, busy_o,
        input  Read_Data_i
    );

    modport master (
        output c_req_i, c_we_i, c_addr_i, c_wdata_i,
        input  c_ack_o, c_rdata_o, c_stall_o,
        output e_req_i, e_we_i, e_addr_i, e_wdata_i,
        input  e_ack_o, e_rdata_o,
        input  Mem_Write_o, Mem_Read_o, Address_o, Write_Data_o, busy_o,
        output Read_Data_i
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Core/external arbiter onto a single data memory port: IDLE -> ACCESS -> RESP.
// Define ARB_CORE_PRIORITY_EN for fixed core priority; otherwise ties are round-robin.
module data_memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_EXT = 1'b0, OWN_CORE = 1'b1} owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d, tie_owner;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_WIDTH-1:0] e_rdata_q, e_rdata_d;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  in_access;

`ifdef ARB_CORE_PRIORITY_EN
    assign tie_owner = OWN_CORE;
`else
    // Previous owner yields a tie; the reset owner (external) hands the core the first tie.
    assign tie_owner = (owner_q == OWN_EXT) ? OWN_CORE : OWN_EXT;
`endif

    always_comb begin
        sel_we    = bus.e_we_i;
        sel_addr  = bus.e_addr_i;
        sel_wdata = bus.e_wdata_i;
        if (owner_q == OWN_CORE) begin
            sel_we    = bus.c_we_i;
            sel_addr  = bus.c_addr_i;
            sel_wdata = bus.c_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_EXT;
            c_rdata_q <= '0;
            e_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            c_rdata_q <= c_rdata_d;
            e_rdata_q <= e_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        c_rdata_d = c_rdata_q;
        e_rdata_d = e_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.c_req_i || bus.e_req_i) begin
                    state_d = ACCESS;
                    if (bus.c_req_i && bus.e_req_i) begin
                        owner_d = tie_owner;
                    end else if (bus.c_req_i) begin
                        owner_d = OWN_CORE;
                    end else begin
                        owner_d = OWN_EXT;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Only reads refresh rdata, so a write leaves the last read value visible.
                if (!sel_we) begin
                    if (owner_q == OWN_CORE) begin
                        c_rdata_d = bus.Read_Data_i;
                    end else begin
                        e_rdata_d = bus.Read_Data_i;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_access        = (state_q == ACCESS);
    assign bus.Mem_Write_o  = in_access & sel_we;
    assign bus.Mem_Read_o   = in_access & ~sel_we;
    assign bus.Address_o    = sel_addr;
    assign bus.Write_Data_o = sel_wdata;
    assign bus.busy_o       = (state_q != IDLE);

    assign bus.c_ack_o   = (state_q == RESP) && (owner_q == OWN_CORE);
    assign bus.e_ack_o   = (state_q == RESP) && (owner_q == OWN_EXT);
    assign bus.c_rdata_o = c_rdata_q;
    assign bus.e_rdata_o = e_rdata_q;
    assign bus.c_stall_o = bus.c_req_i & ~bus.c_ack_o;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter with a behavioural 256-word data memory.
// Build with ARB_CORE_PRIORITY_EN defined to check the fixed-priority variant.
module tb_data_memory_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:255];
    logic          ld_en;
    logic [7:0]    ld_addr;
    logic [DW-1:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (bus.Mem_Write_o) mem[bus.Address_o[7:0]] <= bus.Write_Data_o;
    end
    assign bus.Read_Data_i = mem[bus.Address_o[7:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          is_core;
        logic          chk;
        logic [DW-1:0] rdata;
        int            rel;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.c_req_i = 0; bus.c_we_i = 0; bus.c_addr_i = '0; bus.c_wdata_i = '0;
        bus.e_req_i = 0; bus.e_we_i = 0; bus.e_addr_i = '0; bus.e_wdata_i = '0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        step();
        ld_en = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        #2;
        step();
        reset = 0;
        step();
    endtask

    // Single transaction on one port from an idle arbiter; checks latency, strobes and rdata.
    task automatic run_txn(input string name, input logic is_core, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] exp_rd);
        int   start;
        int   wr_cycles;
        bit   got;
        exp_t e;
        logic ack, other_ack;
        logic [DW-1:0] rd;
        if (is_core) begin
            bus.c_req_i = 1; bus.c_we_i = we; bus.c_addr_i = addr; bus.c_wdata_i = wdata;
        end else begin
            bus.e_req_i = 1; bus.e_we_i = we; bus.e_addr_i = addr; bus.e_wdata_i = wdata;
        end
        start = cyc;
        sb.push_back('{is_core, ~we, exp_rd, 2});
        wr_cycles = 0;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            ack       = is_core ? bus.c_ack_o : bus.e_ack_o;
            other_ack = is_core ? bus.e_ack_o : bus.c_ack_o;
            rd        = is_core ? bus.c_rdata_o : bus.e_rdata_o;
            if (bus.Mem_Write_o === 1'b1) wr_cycles++;
            if (cyc - start == 0) begin
                tests++;
                if (bus.c_stall_o !== is_core || bus.busy_o !== 1'b0 ||
                    bus.Mem_Read_o !== 1'b0 || bus.Mem_Write_o !== 1'b0) begin
                    fails++;
                    $display("FAIL %s.request_cycle: stall=%b busy=%b rd=%b wr=%b, required stall=%b busy=0 rd=0 wr=0",
                             name, bus.c_stall_o, bus.busy_o, bus.Mem_Read_o, bus.Mem_Write_o, is_core);
                end
            end
            if (cyc - start == 1) begin
                tests++;
                if (bus.Mem_Read_o !== ~we || bus.Mem_Write_o !== we || bus.Address_o !== addr ||
                    (we && bus.Write_Data_o !== wdata) || bus.c_stall_o !== is_core) begin
                    fails++;
                    $display("FAIL %s.access_cycle: rd=%b wr=%b addr=%h wdata=%h stall=%b, required rd=%b wr=%b addr=%h wdata=%h stall=%b",
                             name, bus.Mem_Read_o, bus.Mem_Write_o, bus.Address_o, bus.Write_Data_o,
                             bus.c_stall_o, ~we, we, addr, wdata, is_core);
                end
            end
            tests++;
            if (other_ack !== 1'b0) begin
                fails++;
                $display("FAIL %s.other_ack: got %b, required 0", name, other_ack);
            end
            if (ack === 1'b1) begin
                got = 1;
                e = sb.pop_front();
                tests++;
                if (cyc - start != e.rel) begin
                    fails++;
                    $display("FAIL %s.ack_latency: got %0d, required %0d", name, cyc - start, e.rel);
                end
                if (e.chk) begin
                    tests++;
                    if (rd !== e.rdata) begin
                        fails++;
                        $display("FAIL %s.rdata: got %h, required %h", name, rd, e.rdata);
                    end
                end
                tests++;
                if (bus.c_stall_o !== 1'b0 || bus.Mem_Read_o !== 1'b0 || bus.Mem_Write_o !== 1'b0) begin
                    fails++;
                    $display("FAIL %s.resp_cycle: stall=%b rd=%b wr=%b, required all 0",
                             name, bus.c_stall_o, bus.Mem_Read_o, bus.Mem_Write_o);
                end
                if (is_core) bus.c_req_i = 0;
                else bus.e_req_i = 0;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s.ack_timeout: no ack within 8 cycles, required ack at +2", name);
            sb.delete();
            idle_inputs();
        end
        tests++;
        if (wr_cycles != (we ? 1 : 0)) begin
            fails++;
            $display("FAIL %s.write_strobe_cycles: got %0d, required %0d", name, wr_cycles, we ? 1 : 0);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1;
        #1;
        tests++;
        if (bus.c_ack_o !== 1'b0 || bus.e_ack_o !== 1'b0 || bus.Mem_Read_o !== 1'b0 ||
            bus.Mem_Write_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL reset.ctrl: c_ack=%b e_ack=%b rd=%b wr=%b busy=%b, required all 0",
                     bus.c_ack_o, bus.e_ack_o, bus.Mem_Read_o, bus.Mem_Write_o, bus.busy_o);
        end
        tests++;
        if (bus.c_rdata_o !== '0 || bus.e_rdata_o !== '0) begin
            fails++;
            $display("FAIL reset.rdata: c=%h e=%h, required 0", bus.c_rdata_o, bus.e_rdata_o);
        end
        step();
        reset = 0;
        step();
    endtask

    task automatic test_core_read();
        run_txn("core_read", 1'b1, 1'b0, 32'h10, '0, 32'hDEAD_BEEF);
    endtask

    task automatic test_ext_write();
        run_txn("ext_write", 1'b0, 1'b1, 32'h20, 32'h1234_5678, '0);
        tests++;
        if (mem[8'h20] !== 32'h1234_5678) begin
            fails++;
            $display("FAIL ext_write.memory: got %h, required 12345678", mem[8'h20]);
        end
        tests++;
        if (bus.c_rdata_o !== 32'hDEAD_BEEF || bus.e_rdata_o !== '0) begin
            fails++;
            $display("FAIL ext_write.rdata_hold: c=%h e=%h, required c=deadbeef e=0",
                     bus.c_rdata_o, bus.e_rdata_o);
        end
        run_txn("core_readback", 1'b1, 1'b0, 32'h20, '0, 32'h1234_5678);
    endtask

    task automatic test_arbitration();
        int   start, rel;
        exp_t e;
        logic got_core;
        logic [DW-1:0] rd;
        apply_reset();
        bus.c_req_i = 1; bus.c_we_i = 0; bus.c_addr_i = 32'h40;
        bus.e_req_i = 1; bus.e_we_i = 0; bus.e_addr_i = 32'h44;
        start = cyc;
`ifdef ARB_CORE_PRIORITY_EN
        sb.push_back('{1'b1, 1'b1, 32'hC0C0_0001, 2});
        sb.push_back('{1'b1, 1'b1, 32'hC0C0_0001, 5});
        sb.push_back('{1'b1, 1'b1, 32'hC0C0_0001, 8});
        sb.push_back('{1'b1, 1'b1, 32'hC0C0_0001, 11});
        sb.push_back('{1'b0, 1'b1, 32'hE0E0_0002, 14});
`else
        sb.push_back('{1'b1, 1'b1, 32'hC0C0_0001, 2});
        sb.push_back('{1'b0, 1'b1, 32'hE0E0_0002, 5});
        sb.push_back('{1'b1, 1'b1, 32'hC0C0_0001, 8});
        sb.push_back('{1'b0, 1'b1, 32'hE0E0_0002, 11});
`endif
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            rel = cyc - start;
            tests++;
            if (bus.Mem_Read_o === 1'b1 && bus.Mem_Write_o === 1'b1) begin
                fails++;
                $display("FAIL arb.strobe_exclusive: rd=1 wr=1 at +%0d, required at most one", rel);
            end
            if (bus.c_ack_o === 1'b1 || bus.e_ack_o === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL arb.unexpected_ack: c_ack=%b e_ack=%b at +%0d, required none",
                             bus.c_ack_o, bus.e_ack_o, rel);
                end else begin
                    e = sb.pop_front();
                    got_core = bus.c_ack_o;
                    rd = got_core ? bus.c_rdata_o : bus.e_rdata_o;
                    if (bus.c_ack_o === bus.e_ack_o || got_core !== e.is_core ||
                        rel != e.rel || rd !== e.rdata) begin
                        fails++;
                        $display("FAIL arb.grant: core=%b at +%0d rdata=%h, required core=%b at +%0d rdata=%h",
                                 got_core, rel, rd, e.is_core, e.rel, e.rdata);
                    end
                end
            end
            if (rel == 11) begin
                bus.c_req_i = 0;
`ifndef ARB_CORE_PRIORITY_EN
                bus.e_req_i = 0;
`endif
            end
            if (rel == 14) bus.e_req_i = 0;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL arb.missing_acks: got %0d outstanding, required 0", sb.size());
        end
        sb.delete();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_during_access();
        bit ack_seen;
        bus.e_req_i = 1; bus.e_we_i = 1; bus.e_addr_i = 32'h30; bus.e_wdata_i = 32'hAAAA_5555;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (bus.Mem_Write_o !== 1'b1 || bus.Address_o !== 32'h30) begin
            fails++;
            $display("FAIL rst_access.pre: wr=%b addr=%h, required wr=1 addr=30", bus.Mem_Write_o, bus.Address_o);
        end
        #1 reset = 1;
        #1;
        tests++;
        if (bus.Mem_Write_o !== 1'b0 || bus.Mem_Read_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.e_ack_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_access.async: wr=%b rd=%b busy=%b e_ack=%b, required all 0",
                     bus.Mem_Write_o, bus.Mem_Read_o, bus.busy_o, bus.e_ack_o);
        end
        step();
        idle_inputs();
        reset = 0;
        tests++;
        if (mem[8'h30] !== 32'h1111_1111) begin
            fails++;
            $display("FAIL rst_access.memory: got %h, required 11111111", mem[8'h30]);
        end
        ack_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.e_ack_o !== 1'b0 || bus.busy_o !== 1'b0) ack_seen = 1;
        end
        tests++;
        if (ack_seen) begin
            fails++;
            $display("FAIL rst_access.no_ack: ack or busy seen=1, required 0");
        end
        step();
    endtask

    task automatic test_withdrawn();
        int events;
        bus.c_req_i = 1; bus.c_we_i = 0; bus.c_addr_i = 32'h10;
        @(negedge clk);
        tests++;
        if (bus.c_stall_o !== 1'b1) begin
            fails++;
            $display("FAIL withdrawn.stall_high: got %b, required 1", bus.c_stall_o);
        end
        bus.c_req_i = 0;
        #1;
        tests++;
        if (bus.c_stall_o !== 1'b0) begin
            fails++;
            $display("FAIL withdrawn.stall_low: got %b, required 0", bus.c_stall_o);
        end
        events = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.Mem_Read_o !== 1'b0 || bus.Mem_Write_o !== 1'b0 || bus.c_ack_o !== 1'b0 ||
                bus.e_ack_o !== 1'b0 || bus.busy_o !== 1'b0) events++;
        end
        tests++;
        if (events != 0) begin
            fails++;
            $display("FAIL withdrawn.activity: got %0d active cycles, required 0", events);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        ld_en = 0; ld_addr = '0; ld_data = '0;
        idle_inputs();
        preload(8'h10, 32'hDEAD_BEEF);
        preload(8'h20, 32'h0000_0000);
        preload(8'h30, 32'h1111_1111);
        preload(8'h40, 32'hC0C0_0001);
        preload(8'h44, 32'hE0E0_0002);
        test_reset();
        test_core_read();
        test_ext_write();
        test_arbitration();
        test_reset_during_access();
        test_withdrawn();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
